fb_sched: RTL and testbench
===========================

FB_SCHED -- requirements
Module: fb_sched

Interface
REQ-001 SHALL have parameter SC_MAX_BURST, default 16, the maximum scanout burst length in words.
REQ-002 SHALL have parameter AGE_LIMIT, default 4, the number of consecutive scanout grants allowed while an L2 request waits.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port l2_en  in  1  L2 request, level-held until l2_ready.
REQ-006 SHALL have port l2_w  in  1  L2 write (1) or read (0).
REQ-007 SHALL have port l2_addr  in  fb_addr_t  L2 word address.
REQ-008 SHALL have port l2_in  in  fb_word_t  L2 write data.
REQ-009 SHALL have port l2_out  out  fb_word_t  L2 read data, valid with l2_ready.
REQ-010 SHALL have port l2_ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have port sc_req  in  1  scanout burst request, level-held until sc_done.
REQ-012 SHALL have port sc_addr  in  fb_addr_t  burst start address.
REQ-013 SHALL have port sc_len  in  $clog2(SC_MAX_BURST+1)  burst length in words.
REQ-014 SHALL have port sc_data  out  fb_word_t  scanout read word, valid with sc_valid.
REQ-015 SHALL have port sc_valid  out  1  one pulse per returned word.
REQ-016 SHALL have port sc_done  out  1  one-cycle burst-complete pulse.
REQ-017 SHALL have ports fb_en, fb_w (out 1), fb_addr (out fb_addr_t), fb_in (out fb_word_t), fb_out (in fb_word_t) and fb_ready (in 1), forming the framebuffer port.

Function
REQ-018 SHALL use the states S_IDLE, S_L2 and S_SC.
REQ-019 In S_IDLE, a pending sc_req SHALL win over l2_en, except as stated in REQ-027.
- On a scanout grant: latch sc_addr and sc_len, clear the word counter, go to S_SC.
- On an L2 grant: latch l2_w, l2_addr and l2_in, go to S_L2.
REQ-020 The grant decision SHALL take one cycle; fb_en SHALL assert the cycle after the grant.
REQ-021 fb_en SHALL stay high with fb_w, fb_addr and fb_in stable until fb_ready, and SHALL drop combinationally in the fb_ready cycle.
REQ-022 In S_L2, on fb_ready, the block SHALL pulse l2_ready, drive l2_out = fb_out in the same cycle and return to S_IDLE.
REQ-023 Once granted, an L2 access SHALL complete even if l2_en drops early; in that case l2_ready still pulses.
REQ-024 In S_SC, fb_w SHALL be 0, and each fb_ready SHALL:
- pulse sc_valid with sc_data = fb_out;
- increment fb_addr modulo 2^width(fb_addr_t), so it wraps to 0;
- increment the word count.
REQ-025 fb_en SHALL re-assert the cycle after each fb_ready until the word count reaches the latched length.
REQ-026 On the last word, sc_done SHALL pulse in the cycle after the final sc_valid, with return to S_IDLE.
REQ-027 Length rules:
- sc_len = 0 SHALL produce no fb access, and sc_done SHALL pulse the cycle after the grant.
- sc_len > SC_MAX_BURST SHALL be clamped to SC_MAX_BURST.
REQ-028 At most one of l2_ready and sc_valid SHALL be high in any cycle.
REQ-029 fb_en SHALL never be high in S_IDLE.

Reset
REQ-030 While rst is high, the following SHALL be 0 and the state SHALL be S_IDLE immediately, regardless of clk:
- fb_en, l2_ready, sc_valid, sc_done;
- the age counter and the word counter.
REQ-031 A reset mid-transaction SHALL abandon that transaction without any completion pulse.
REQ-032 The first grant SHALL be possible on the first rising edge after rst falls.

Configuration
REQ-033 When FB_SCHED_AGING_EN is defined:
- an age counter SHALL increment on each scanout grant made while l2_en is high;
- it SHALL clear on each L2 grant;
- at AGE_LIMIT, the next S_IDLE decision SHALL grant L2 even if sc_req is high.
REQ-034 When FB_SCHED_AGING_EN is undefined, scanout SHALL have strict priority and no age counter SHALL exist.

Structure
REQ-035 fb_addr_t and fb_word_t SHALL come from the attrs package.
REQ-036 The state enum and SC_MAX_BURST's default SHALL live in a shared fb_sched package.
REQ-037 The block SHALL be a single module with no sub-modules; the burst address/count generator SHALL be inline.

Verification
REQ-038 Single L2 read: l2_addr=0x100, fb_out=0xABCD, fb_ready 3 cycles after fb_en -> one l2_ready pulse with l2_out=0xABCD, and fb_en low in the next cycle.
REQ-039 Burst: sc_addr=0x20, sc_len=4 -> fb_addr sequence 0x20..0x23, four sc_valid pulses, one sc_done pulse, and no L2 activity.
REQ-040 Wrap: sc_addr = all-ones, sc_len=2 -> fb_addr sequence all-ones then 0.
REQ-041 Aging (macro on, AGE_LIMIT=4): sc_req and l2_en both held high -> four bursts, then the L2 access, then scanout resumes; with the macro off, L2 never granted while sc_req is held high.
REQ-042 Edge cases:
- sc_len=0 -> sc_done pulse with no fb_en assertion.
- sc_len=20 -> exactly 16 sc_valid pulses.
REQ-043 Reset: rst asserted on the 2nd word of an 8-word burst -> fb_en falls without waiting for clk, no sc_done pulse, and an L2 request served correctly after rst falls.

Source files
------------

// File: rtl/attrs_pkg.sv
// rtl/attrs_pkg.sv - framebuffer address and word types shared across the memory subsystem
package attrs_pkg;
  localparam int FB_ADDR_W = 16;
  localparam int FB_WORD_W = 16;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_WORD_W-1:0] fb_word_t;
endpackage

// File: rtl/fb_sched_pkg.sv
// rtl/fb_sched_pkg.sv - fb_sched state encoding and default burst/aging limits
package fb_sched_pkg;
  localparam int FB_SC_MAX_BURST = 16;
  localparam int FB_AGE_LIMIT    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L2   = 2'd1,
    S_SC   = 2'd2
  } fb_state_e;
endpackage

// File: rtl/fb_sched_if.sv
// rtl/fb_sched_if.sv - L2, scanout and framebuffer port bundle; slave = scheduler side
interface fb_sched_if #(
  parameter int SC_MAX_BURST = fb_sched_pkg::FB_SC_MAX_BURST
);
  import attrs_pkg::*;

  localparam int LEN_W = $clog2(SC_MAX_BURST + 1);

  logic             l2_en;
  logic             l2_w;
  fb_addr_t         l2_addr;
  fb_word_t         l2_in;
  fb_word_t         l2_out;
  logic             l2_ready;

  logic             sc_req;
  fb_addr_t         sc_addr;
  logic [LEN_W-1:0] sc_len;
  fb_word_t         sc_data;
  logic             sc_valid;
  logic             sc_done;

  logic             fb_en;
  logic             fb_w;
  fb_addr_t         fb_addr;
  fb_word_t         fb_in;
  fb_word_t         fb_out;
  logic             fb_ready;

  modport slave (
    input  l2_en, l2_w, l2_addr, l2_in,
    output l2_out, l2_ready,
    input  sc_req, sc_addr, sc_len,
    output sc_data, sc_valid, sc_done,
    output fb_en, fb_w, fb_addr, fb_in,
    input  fb_out, fb_ready
  );

  modport master (
    output l2_en, l2_w, l2_addr, l2_in,
    input  l2_out, l2_ready,
    output sc_req, sc_addr, sc_len,
    input  sc_data, sc_valid, sc_done,
    input  fb_en, fb_w, fb_addr, fb_in,
    output fb_out, fb_ready
  );
endinterface

// File: rtl/fb_sched.sv
// rtl/fb_sched.sv - arbitrates one framebuffer port between L2 accesses and scanout bursts
// Optional L2 anti-starvation aging is enabled by defining FB_SCHED_AGING_EN.
module fb_sched
  import fb_sched_pkg::*;
  import attrs_pkg::*;
#(
  parameter int SC_MAX_BURST = FB_SC_MAX_BURST,
  parameter int AGE_LIMIT    = FB_AGE_LIMIT
) (
  input  logic      clk,
  input  logic      rst,
  fb_sched_if.slave bus
);
  localparam int LEN_W = $clog2(SC_MAX_BURST + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SC_MAX_BURST);

  fb_state_e        state_q, state_d;
  fb_addr_t         addr_q, addr_d;
  fb_word_t         wdata_q, wdata_d;
  logic             w_q, w_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             sc_grant;

`ifdef FB_SCHED_AGING_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);

  logic [AGE_W-1:0] age_q, age_d;

  // Once L2 has watched AGE_LIMIT scanout grants go by, it wins the next decision.
  assign sc_grant = bus.sc_req && !(bus.l2_en && (age_q >= AGE_W'(AGE_LIMIT)));

  always_comb begin
    age_d = age_q;
    if (state_q == S_IDLE && bus.l2_en) begin
      if (sc_grant) age_d = age_q + AGE_W'(1);
      else          age_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) age_q <= '0;
    else     age_q <= age_d;
  end
`else
  localparam int unused_age_limit = AGE_LIMIT;

  assign sc_grant = bus.sc_req;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    w_d          = w_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    bus.fb_en    = 1'b0;
    bus.l2_ready = 1'b0;
    bus.sc_valid = 1'b0;
    bus.sc_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sc_grant) begin
          state_d = S_SC;
          addr_d  = bus.sc_addr;
          w_d     = 1'b0;
          cnt_d   = '0;
          len_d   = (bus.sc_len > MAX_LEN) ? MAX_LEN : bus.sc_len;
        end else if (bus.l2_en) begin
          state_d = S_L2;
          addr_d  = bus.l2_addr;
          w_d     = bus.l2_w;
          wdata_d = bus.l2_in;
        end
      end
      S_L2: begin
        bus.fb_en = !bus.fb_ready;
        if (bus.fb_ready) begin
          bus.l2_ready = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_SC: begin
        // A zero-length burst lands here with cnt == len and completes at once.
        if (cnt_q == len_q) begin
          bus.sc_done = 1'b1;
          state_d     = S_IDLE;
        end else begin
          bus.fb_en = !bus.fb_ready;
          if (bus.fb_ready) begin
            bus.sc_valid = 1'b1;
            addr_d       = addr_q + fb_addr_t'(1);
            cnt_d        = cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      w_q     <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      w_q     <= w_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fb_w    = w_q;
  assign bus.fb_addr = addr_q;
  assign bus.fb_in   = wdata_q;
  assign bus.l2_out  = bus.fb_out;
  assign bus.sc_data = bus.fb_out;
endmodule

// File: tb/tb_fb_sched.sv
// tb/tb_fb_sched.sv - directed bench for fb_sched; aging expectations follow FB_SCHED_AGING_EN
module tb_fb_sched;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   lat;

  fb_sched_if #(.SC_MAX_BURST(16)) bus ();

  fb_sched #(.SC_MAX_BURST(16), .AGE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A5A;
  endfunction

  // Memory: raises fb_ready for one cycle after fb_en has been seen for lat cycles.
  initial begin
    int mcnt;
    mcnt = 0;
    mem[16'h0100] = 16'hABCD;
    bus.fb_ready = 1'b0;
    bus.fb_out   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || bus.fb_ready) begin
        bus.fb_ready = 1'b0;
        mcnt = 0;
      end else if (bus.fb_en) begin
        if (mcnt == lat) begin
          bus.fb_ready = 1'b1;
          if (bus.fb_w) mem[bus.fb_addr] = bus.fb_in;
          else          bus.fb_out = rd(bus.fb_addr);
        end else begin
          mcnt++;
        end
      end
    end
  end

  int          cyc, n_done, n_l2, n_fb_en, n_fbw, n_excl, last_valid_cyc, last_done_cyc;
  logic [15:0] sc_addrs[$];
  logic [15:0] sc_words[$];

  initial begin
    cyc = 0; n_done = 0; n_l2 = 0; n_fb_en = 0; n_fbw = 0; n_excl = 0;
    last_valid_cyc = -1; last_done_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.fb_en) n_fb_en++;
        if (bus.fb_en && bus.fb_w) n_fbw++;
        if (bus.sc_valid) begin
          sc_addrs.push_back(bus.fb_addr);
          sc_words.push_back(bus.sc_data);
          last_valid_cyc = cyc;
        end
        if (bus.sc_done) begin
          n_done++;
          last_done_cyc = cyc;
        end
        if (bus.l2_ready) n_l2++;
        if (bus.l2_ready && bus.sc_valid) n_excl++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic l2_op(input bit w, input logic [15:0] a, input logic [15:0] d, input bit drop,
                       output logic [15:0] q, output int n, output bit ok);
    bus.l2_en = 1'b1; bus.l2_w = w; bus.l2_addr = a; bus.l2_in = d;
    q = '0; n = -1; ok = 1'b0;
    tick();
    if (drop) bus.l2_en = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (bus.l2_ready) begin
        ok = 1'b1; q = bus.l2_out; n = i;
      end else begin
        tick();
      end
    end
    bus.l2_en = 1'b0;
    tick();
  endtask

  task automatic burst(input logic [15:0] a, input logic [4:0] len, output int n, output bit ok);
    bus.sc_req = 1'b1; bus.sc_addr = a; bus.sc_len = len;
    n = -1; ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (bus.sc_done) begin
        ok = 1'b1; n = i;
      end
    end
    bus.sc_req = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] q;
    int          n, v0, d0, l0, e0, w0, done_at_l2;
    bit          ok, got_l2, resumed;

    n_vec = 0; n_err = 0; lat = 3;
    rst = 1'b1;
    bus.l2_en = 1'b0; bus.l2_w = 1'b0; bus.l2_addr = '0; bus.l2_in = '0;
    bus.sc_req = 1'b0; bus.sc_addr = '0; bus.sc_len = '0;
    tick(); tick();
    chk("reset fb_en", bus.fb_en, 0);
    chk("reset l2_ready", bus.l2_ready, 0);
    chk("reset sc_valid", bus.sc_valid, 0);
    chk("reset sc_done", bus.sc_done, 0);

    // L2 read requested as reset falls; memory answers 3 cycles after fb_en.
    rst = 1'b0;
    l0 = n_l2;
    l2_op(1'b0, 16'h0100, 16'h0000, 1'b0, q, n, ok);
    chk("l2 read done", ok, 1);
    chk("l2 read data", q, 16'hABCD);
    chk("l2 read latency", n, 3);
    chk("l2 fb_en after", bus.fb_en, 0);
    chk("l2 read pulses", n_l2 - l0, 1);

    lat = 2;
    l2_op(1'b1, 16'h0200, 16'h1234, 1'b1, q, n, ok);
    chk("l2 write early drop done", ok, 1);
    l2_op(1'b0, 16'h0200, 16'h0000, 1'b0, q, n, ok);
    chk("l2 write readback", q, 16'h1234);

    lat = 1;
    v0 = sc_addrs.size(); d0 = n_done; l0 = n_l2; w0 = n_fbw;
    burst(16'h0020, 5'd4, n, ok);
    chk("burst done", ok, 1);
    chk("burst words", sc_addrs.size() - v0, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("burst addr %0d", i), sc_addrs[v0 + i], 16'h0020 + 16'(i));
      chk($sformatf("burst data %0d", i), sc_words[v0 + i], rd(16'h0020 + 16'(i)));
    end
    chk("burst sc_done count", n_done - d0, 1);
    chk("burst sc_done timing", last_done_cyc, last_valid_cyc + 1);
    chk("burst no l2", n_l2 - l0, 0);
    chk("burst no writes", n_fbw - w0, 0);

    v0 = sc_addrs.size();
    burst(16'hFFFF, 5'd2, n, ok);
    chk("wrap words", sc_addrs.size() - v0, 2);
    chk("wrap addr 0", sc_addrs[v0], 16'hFFFF);
    chk("wrap addr 1", sc_addrs[v0 + 1], 16'h0000);

    v0 = sc_addrs.size(); d0 = n_done; e0 = n_fb_en;
    burst(16'h0300, 5'd0, n, ok);
    chk("len0 done", ok, 1);
    chk("len0 done cycle", n, 0);
    chk("len0 no fb_en", n_fb_en - e0, 0);
    chk("len0 no words", sc_addrs.size() - v0, 0);

    v0 = sc_addrs.size();
    burst(16'h0400, 5'd20, n, ok);
    chk("len20 clamped words", sc_addrs.size() - v0, 16);

    d0 = n_done; l0 = n_l2;
    bus.sc_addr = 16'h0040; bus.sc_len = 5'd2; bus.sc_req = 1'b1;
    bus.l2_en = 1'b1; bus.l2_w = 1'b0; bus.l2_addr = 16'h0100;
`ifdef FB_SCHED_AGING_EN
    got_l2 = 1'b0; resumed = 1'b0; done_at_l2 = -1; q = '0;
    for (int i = 0; i < 300 && !resumed; i++) begin
      tick();
      if (bus.l2_ready && !got_l2) begin
        got_l2 = 1'b1; done_at_l2 = n_done - d0; q = bus.l2_out; bus.l2_en = 1'b0;
      end else if (got_l2 && bus.sc_done) begin
        resumed = 1'b1;
      end
    end
    bus.sc_req = 1'b0; bus.l2_en = 1'b0;
    tick();
    chk("aging l2 granted", got_l2, 1);
    chk("aging bursts before l2", done_at_l2, 4);
    chk("aging l2 data", q, 16'hABCD);
    chk("aging scanout resumes", resumed, 1);
`else
    for (int i = 0; i < 150; i++) tick();
    chk("strict no l2 under scanout", n_l2 - l0, 0);
    chk("strict bursts continue", (n_done - d0) >= 10, 1);
    bus.sc_req = 1'b0;
    got_l2 = 1'b0; q = '0;
    for (int i = 0; i < 60 && !got_l2; i++) begin
      tick();
      if (bus.l2_ready) begin
        got_l2 = 1'b1; q = bus.l2_out;
      end
    end
    bus.l2_en = 1'b0;
    tick();
    chk("strict l2 after scanout", got_l2, 1);
    chk("strict l2 data", q, 16'hABCD);
`endif

    // Reset mid-cycle while the second word of an 8-word burst is outstanding.
    v0 = sc_addrs.size(); d0 = n_done;
    bus.sc_addr = 16'h0080; bus.sc_len = 5'd8; bus.sc_req = 1'b1;
    n = 0;
    while (!(sc_addrs.size() == v0 + 1 && bus.fb_en && !bus.fb_ready) && n < 100) begin
      tick();
      n++;
    end
    chk("rst pre fb_en", bus.fb_en, 1);
    chk("rst pre fb_addr", bus.fb_addr, 16'h0081);
    rst = 1'b1; bus.sc_req = 1'b0;
    #1;
    chk("rst async fb_en", bus.fb_en, 0);
    chk("rst async sc_valid", bus.sc_valid, 0);
    chk("rst async sc_done", bus.sc_done, 0);
    chk("rst async l2_ready", bus.l2_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();
    chk("rst no sc_done", n_done - d0, 0);
    chk("rst words before abort", sc_addrs.size() - v0, 1);
    lat = 2;
    l2_op(1'b0, 16'h0200, 16'h0000, 1'b0, q, n, ok);
    chk("post-rst l2 done", ok, 1);
    chk("post-rst l2 data", q, 16'h1234);

    chk("l2_ready/sc_valid exclusive", n_excl, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
